// File: rtl/capture_trigger.sv
// capture_trigger: edge-triggered logic-analyzer capture engine.
// Once armed it samples the four channels at a programmable rate. It waits for
// the selected edge on the trigger channel, then streams DEPTH samples to the
// sample store as single-cycle registered writes.
module capture_trigger #(
   parameter int DEPTH = 800,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       ch_in,
   input  logic             arm,
   input  logic             abort,
   input  logic [1:0]       trig_ch,
   input  logic             trig_edge,
   input  logic [DIV_W-1:0] rate_div,
   output logic             wr_en,
   output logic [9:0]       wr_addr,
   output logic [3:0]       wr_data,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // The index is one bit wider than the address, so it can reach DEPTH.
   // That value marks the frame as fully sampled.
   localparam logic [10:0] DEPTH_IDX = 11'(DEPTH);
   localparam logic [9:0]  LAST_ADDR = 10'(DEPTH - 1);

   state_t           state, state_nxt;
   logic [DIV_W-1:0] rate_q;       // sample period captured at arm
   logic [1:0]       trig_ch_q;    // trigger channel captured at arm
   logic             rise_q;       // 1 = rising-edge trigger, captured at arm
   logic [DIV_W-1:0] pre_cnt;      // prescaler, 0..rate_q
   logic             prev;         // trigger channel value at the previous tick
   logic             first_tick;   // next tick only seeds prev
   logic [10:0]      sample_idx;   // index of the next sample to write

   logic running;
   logic tick;
   logic arm_ok;
   logic trig_bit;
   logic edge_seen;
   logic trig_hit;
   logic capture;
   logic last_write;

   // Decode ticks, trigger detection and capture qualification.
   always_comb begin
      running    = (state == ARMED) || (state == CAPTURE);
      tick       = running && (pre_cnt == rate_q);
      arm_ok     = arm && !abort && ((state == IDLE) || (state == DONE));
      trig_bit   = ch_in[trig_ch_q];
      edge_seen  = rise_q ? (!prev && trig_bit) : (prev && !trig_bit);
      trig_hit   = (state == ARMED) && tick && !first_tick && edge_seen;
      // An abort on the same cycle suppresses the write that would follow.
      capture    = !abort &&
                   (trig_hit || ((state == CAPTURE) && tick && (sample_idx != DEPTH_IDX)));
      // The final write is on the bus now, so done rises on the next cycle.
      last_write = (state == CAPTURE) && wr_en && (wr_addr == LAST_ADDR);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Abort overrides every other transition.
   always_comb begin
      // NOTE: assigning a default first means every path drives state_nxt, so no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (arm_ok)     state_nxt = ARMED;
         ARMED:   if (trig_hit)   state_nxt = CAPTURE;
         CAPTURE: if (last_write) state_nxt = DONE;
         DONE:    if (arm_ok)     state_nxt = ARMED;
         default:                 state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
      end
   end

   // Status outputs are decoded straight from the state.
   always_comb begin
      busy = (state == ARMED) || (state == CAPTURE);
      done = (state == DONE);
   end

   // Prescaler, latched configuration, trigger history and write port.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (rst) begin
         rate_q     <= '0;
         trig_ch_q  <= '0;
         rise_q     <= 1'b0;
         pre_cnt    <= '0;
         prev       <= 1'b0;
         first_tick <= 1'b0;
         sample_idx <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         // The prescaler runs only while the engine stays in ARMED or CAPTURE.
         // At all other times it is held at zero.
         if (running && ((state_nxt == ARMED) || (state_nxt == CAPTURE))) begin
            pre_cnt <= tick ? '0 : pre_cnt + DIV_W'(1);
         end else begin
            pre_cnt <= '0;
         end

         // Configuration is frozen at arm. Later input changes are ignored.
         if (arm_ok) begin
            rate_q     <= rate_div;
            trig_ch_q  <= trig_ch;
            rise_q     <= trig_edge;
            first_tick <= 1'b1;
            sample_idx <= '0;
         end

         // Every ARMED tick refreshes the trigger history.
         if ((state == ARMED) && tick && !abort) begin
            prev       <= trig_bit;
            first_tick <= 1'b0;
         end

         // Registered single-cycle write. The address holds between writes.
         wr_en <= capture;
         if (capture) begin
            wr_addr    <= sample_idx[9:0];
            wr_data    <= ch_in;
            sample_idx <= sample_idx + 11'd1;
         end
      end
   end

endmodule

// File: tb/tb_capture_trigger.sv
// Randomised bench for capture_trigger. For each arm, a reference model works
// out the full write stream from the tick schedule (tick k lands (k+1)*(R+1)
// cycles after arm). It then queues the expected writes, and a monitor pops one
// entry per wr_en.
module tb_capture_trigger;

   localparam int DEPTH = 800;
   localparam int DIV_W = 16;
   localparam int MAXL  = 4096;

   logic             clk;
   logic             rst;
   logic [3:0]       ch_in;
   logic             arm;
   logic             abort;
   logic [1:0]       trig_ch;
   logic             trig_edge;
   logic [DIV_W-1:0] rate_div;
   logic             wr_en;
   logic [9:0]       wr_addr;
   logic [3:0]       wr_data;
   logic             busy;
   logic             done;

   typedef struct {
      int         edge_no;
      int         addr;
      logic [3:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [3:0] chs[MAXL];
   int         n_checks = 0;
   int         n_fail = 0;
   int         exp_hold = 0;
   int         exp_last_rel = -1;
   int         edge_n = 0;
   bit         mon_en = 1'b0;

   capture_trigger #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk(clk),
      .rst(rst),
      .ch_in(ch_in),
      .arm(arm),
      .abort(abort),
      .trig_ch(trig_ch),
      .trig_edge(trig_edge),
      .rate_div(rate_div),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write must match the head of the expected queue.
   // Between writes, the address must hold its last value.
   always @(negedge clk) begin
      wr_t e;
      if (mon_en) begin
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("wr_edge", edge_n, e.edge_no);
               check("wr_addr", int'(wr_addr), e.addr);
               check("wr_data", int'(wr_data), int'(e.data));
               exp_hold = e.addr;
            end
         end else begin
            check("addr_hold", int'(wr_addr), exp_hold);
         end
      end
   end

   // Channel trace: trigger bit = init before sw, !init for `hold` cycles, then random or held.
   task automatic gen(input int len, input int ch, input bit init, input int sw,
                      input int hold, input bit rand_after);
      logic [3:0] v;
      for (int j = 0; j < len; j++) begin
         v = 4'($urandom);
         if (j < sw)                          v[ch] = init;
         else if (j < sw + hold || !rand_after) v[ch] = !init;
         chs[j] = v;
      end
   endtask

   // Reference model: tick k samples chs[(k+1)*(R+1)].
   // Tick 0 seeds the history, and the first qualifying edge starts the frame.
   task automatic model(input int a, input int r, input int ch, input bit rising, input int stop);
      int  trig_k;
      int  p;
      bit  prev_b;
      bit  cur;
      wr_t w;
      exp_last_rel = -1;
      trig_k = -1;
      prev_b = 1'b0;
      for (int k = 0; (k + 1) * (r + 1) < stop; k++) begin
         p   = (k + 1) * (r + 1);
         cur = chs[p][ch];
         if (k > 0 && (rising ? (!prev_b && cur) : (prev_b && !cur))) begin
            trig_k = k;
            break;
         end
         prev_b = cur;
      end
      if (trig_k >= 0) begin
         for (int i = 0; i < DEPTH; i++) begin
            p = (trig_k + i + 1) * (r + 1);
            if (p >= stop) break;
            w.edge_no = a + p;
            w.addr    = i;
            w.data    = chs[p];
            exp_q.push_back(w);
            if (i == DEPTH - 1) exp_last_rel = p;
         end
      end
   endtask

   // Arm at j=0, drive the trace, and apply the optional abort, reset, rate change and re-arm.
   // Call it #1 after a rising edge.
   task automatic run(input int len, input int r, input int ch, input bit rising,
                      input int abort_j, input int rst_j, input int rate_j,
                      input int rate_new, input int rearm_j);
      int a;
      int stop;
      stop = len;
      if (abort_j >= 0 && abort_j < stop) stop = abort_j;
      if (rst_j >= 0 && rst_j < stop)     stop = rst_j;
      rate_div  = DIV_W'(r);
      trig_ch   = 2'(ch);
      trig_edge = rising;
      a = edge_n + 1;
      model(a, r, ch, rising, stop);
      for (int j = 0; j < len; j++) begin
         arm   = (j == 0) || (j == rearm_j);
         abort = (j == abort_j);
         rst   = (j == rst_j);
         ch_in = chs[j];
         if (j == rate_j) rate_div = DIV_W'(rate_new);
         @(posedge clk);
         #1;
         if (j == 0 && abort_j != 0 && rst_j != 0) begin
            check("arm_busy", int'(busy), 1);
            check("arm_done", int'(done), 0);
         end
         if (j == abort_j) begin
            check("abort_busy", int'(busy), 0);
            check("abort_done", int'(done), 0);
            check("abort_wr_en", int'(wr_en), 0);
         end
         if (j == rst_j) begin
            exp_hold = 0;
            check("rst_wr_en", int'(wr_en), 0);
            check("rst_wr_addr", int'(wr_addr), 0);
            check("rst_wr_data", int'(wr_data), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
         end
         if (exp_last_rel >= 0 && j == exp_last_rel) begin
            check("last_wr_done", int'(done), 0);
            check("last_wr_busy", int'(busy), 1);
         end
         if (exp_last_rel >= 0 && j == exp_last_rel + 1) begin
            check("done_set", int'(done), 1);
            check("done_busy", int'(busy), 0);
            check("done_wr_en", int'(wr_en), 0);
         end
      end
      arm   = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      int r;
      int ch;
      int tk;
      int pos;
      bit rising;

      rst       = 1'b1;
      arm       = 1'b0;
      abort     = 1'b0;
      ch_in     = '0;
      trig_ch   = '0;
      trig_edge = 1'b1;
      rate_div  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_wr_en", int'(wr_en), 0);
      check("reset_wr_addr", int'(wr_addr), 0);
      check("reset_wr_data", int'(wr_data), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Without an arm, the block stays idle whatever the channels do.
      for (int j = 0; j < 10; j++) begin
         ch_in = 4'($urandom);
         @(posedge clk);
         #1;
      end
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);

      // Rising edge on ch2 five cycles after arm, one sample per cycle.
      gen(810, 2, 1'b0, 5, 2, 1'b1);
      run(810, 0, 2, 1'b1, -1, -1, -1, 0, -1);

      // Re-arm from DONE. A stray arm mid-capture must be ignored.
      ch = int'($urandom_range(0, 3));
      gen(815, ch, 1'b0, 10, 2, 1'b1);
      run(815, 0, ch, 1'b1, -1, -1, -1, 0, 300);

      // Period of 4 cycles. Changing rate_div mid-capture must not change the spacing.
      gen(3225, 1, 1'b0, 20, 8, 1'b1);
      run(3225, 3, 1, 1'b1, -1, -1, 1000, 9, -1);

      // arm and abort together in DONE: abort wins.
      arm   = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      arm   = 1'b0;
      abort = 1'b0;
      check("arm_abort_busy", int'(busy), 0);
      check("arm_abort_done", int'(done), 0);

      // Falling trigger on ch0, held high at arm.
      gen(1615, 0, 1'b1, 12, 4, 1'b1);
      run(1615, 1, 0, 1'b0, -1, -1, -1, 0, -1);

      // Falling trigger selected, but ch0 only rises: stays ARMED with no writes.
      gen(60, 0, 1'b0, 10, 0, 1'b0);
      run(60, 0, 0, 1'b0, -1, -1, -1, 0, -1);
      check("no_trig_busy", int'(busy), 1);
      check("no_trig_done", int'(done), 0);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("no_trig_abort_busy", int'(busy), 0);

      // Abort right after the write to addr 100. The next sample's write must be dropped.
      ch = int'($urandom_range(0, 3));
      gen(140, ch, 1'b0, 8, 2, 1'b1);
      tk  = 7;                       // first tick at or after cycle 8 with one-cycle ticks
      pos = (tk + 101) * 1;          // tick that produces the write to addr 100
      run(pos + 21, 0, ch, 1'b1, pos + 1, -1, -1, 0, -1);

      // Reset just after the write to addr 400, then nothing until a new arm.
      r      = int'($urandom_range(0, 2));
      ch     = int'($urandom_range(0, 3));
      rising = 1'($urandom);
      gen(MAXL, ch, !rising, 8, 2 * (r + 1), 1'b1);
      tk  = (8 + r) / (r + 1) - 1;
      pos = (tk + 401) * (r + 1);
      run(pos + 21, r, ch, rising, -1, pos + 1, -1, 0, -1);

      // A full frame after reset to show the engine recovers.
      r      = int'($urandom_range(0, 1));
      ch     = int'($urandom_range(0, 3));
      rising = 1'($urandom);
      gen(MAXL, ch, !rising, 9, 2 * (r + 1), 1'b1);
      tk = (9 + r) / (r + 1) - 1;
      run((tk + DEPTH + 1) * (r + 1) + 5, r, ch, rising, -1, -1, -1, 0, -1);

      repeat (5) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/capture_trigger.md
CAPTURE_TRIGGER -- requirements
Module: capture_trigger

Interface
REQ-001 Parameter DEPTH, default 800: samples captured per frame (one per display pixel column).
REQ-002 Parameter DIV_W, default 16: width of the sample-rate divider.
REQ-003 clk  input  1  sole clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 ch_in  input  4  logic-analyzer channels, already synchronized to clk.
REQ-006 arm  input  1  single-cycle request to start a capture.
REQ-007 abort  input  1  single-cycle request to cancel the current capture.
REQ-008 trig_ch  input  2  index of the trigger channel.
REQ-009 trig_edge  input  1  trigger edge select: 1 = rising, 0 = falling.
REQ-010 rate_div  input  DIV_W  sample period minus one, in clk cycles.
REQ-011 wr_en  output  1  write strobe to the sample store.
REQ-012 wr_addr  output  10  sample index, 0..DEPTH-1.
REQ-013 wr_data  output  4  sampled channel word.
REQ-014 busy  output  1  high in ARMED and CAPTURE.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 The FSM SHALL have four states: IDLE, ARMED, CAPTURE, DONE.
REQ-017 On arm in IDLE or DONE, the block SHALL enter ARMED and latch rate_div, trig_ch and trig_edge; later input changes have no effect until the next arm.
REQ-018 Prescaler: cleared to 0 on arm; counts 0..latched rate_div in ARMED/CAPTURE; tick fires on the cycle count == rate_div, then wraps to 0; rate_div = 0 gives a tick every cycle.
REQ-019 Prescaler SHALL hold at 0 in IDLE and DONE.
REQ-020 The first tick after arm SHALL only load prev = ch_in[trig_ch]; no trigger is possible on that tick.
REQ-021 On later ARMED ticks, trigger fires when (prev, ch_in[trig_ch]) = (0,1) for rising or (1,0) for falling; prev updates on every tick.
REQ-022 On trigger the FSM SHALL enter CAPTURE; the triggering tick's sample is frame sample 0.
REQ-023 Each captured tick SHALL produce one registered write on the next cycle: wr_en=1 for exactly one cycle, wr_data = ch_in at the tick, wr_addr = sample index.
REQ-024 Sample index SHALL start at 0 and increment by 1 per write; it never wraps within a frame.
REQ-025 After the write to address DEPTH-1, the FSM SHALL enter DONE; done=1 from the cycle after that wr_en.
REQ-026 Exactly DEPTH writes SHALL occur per completed frame; no writes occur in IDLE, ARMED (non-trigger ticks) or DONE.
REQ-027 arm SHALL be ignored in ARMED and CAPTURE.
REQ-028 abort in any state SHALL return to IDLE next cycle; busy, done and wr_en go to 0; a write already scheduled for that cycle is suppressed.
REQ-029 If arm and abort are asserted together, abort SHALL win.
REQ-030 wr_addr SHALL hold its last value when wr_en=0.

Reset
REQ-031 While rst=1: state = IDLE; prescaler, sample index and prev cleared; wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0.
REQ-032 rst SHALL take priority over arm and abort; reset mid-capture abandons the frame with no further writes.
REQ-033 After rst deasserts, the block SHALL wait in IDLE for arm.

Verification
REQ-034 rate_div=0, trig_ch=2, trig_edge=1; arm, then ch_in[2] goes 0->1 five cycles later -> exactly 800 wr_en pulses on consecutive cycles, addr 0..799, addr 0 data has bit2=1, done high the cycle after addr 799.
REQ-035 rate_div=3 -> wr_en pulses exactly 4 cycles apart; changing rate_div to 9 mid-capture leaves the spacing at 4.
REQ-036 trig_edge=0 with ch_in[0] held 1 at arm, then 1->0 -> triggers; a 0->1 transition alone -> stays ARMED, no writes.
REQ-037 Abort after the write to addr 100 -> IDLE next cycle, no further wr_en, busy=0, done=0; arm and abort together in DONE -> IDLE.
REQ-038 rst=1 asserted during CAPTURE at addr 400 -> all outputs 0 next cycle, no writes until a new arm and trigger.
REQ-039 arm in DONE -> done=0, busy=1; a second frame writes addr 0..799 again.
